// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file sequencer.
// Optional build macro REGFILE_SEQ_R0_ZERO_EN is consumed in regfile_seq.sv.
package regfile_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int NREGS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr, input int nregs);
        return int'(addr) >= nregs;
    endfunction

endpackage

// File: rtl/regfile_seq_runcnt.sv
// Saturating count of consecutive writeback grants made while a read waits.
module regfile_seq_runcnt #(
    parameter int MAX_WB_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [3:0] run;

    always_ff @(posedge clk) begin
        if (rst)
            run <= 4'd0;
        else if (clr)
            run <= 4'd0;
        else if (inc && run != 4'd15)
            run <= run + 4'd1;
    end

    assign at_limit = (run >= 4'(MAX_WB_RUN));

endmodule

// File: rtl/regfile_seq.sv
// Arbitrates one single-port register file between decode operand reads and writebacks.
// Build macro REGFILE_SEQ_R0_ZERO_EN: register 0 reads as zero and ignores writes.
module regfile_seq
    import regfile_pkg::*;
#(
    parameter int NREGS      = NREGS_DEF,
    parameter int MAX_WB_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_single,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              rsp_err,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_err,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    state_t            state;
    logic [ADDR_W-1:0] rs_q, rt_q;
    logic              single_q, err_q;
    logic              wb_grant, rd_grant, at_limit, run_inc, run_clr;
    logic              wr_oor, wr_zero;

    function automatic logic is_r0(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_SEQ_R0_ZERO_EN
        return a == '0;
`else
        return a != a;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        return (addr_oor(a, NREGS) || is_r0(a)) ? '0 : rf_rdata;
    endfunction

    assign wr_oor  = addr_oor(wb_addr, NREGS);
    assign wr_zero = is_r0(wb_addr);

    // In RESP the read has already completed, so a waiting writeback always wins.
    always_comb begin
        wb_grant = 1'b0;
        rd_grant = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    wb_grant = wb_valid && (!req_valid || !at_limit);
                    rd_grant = req_valid && !wb_grant;
                end
                RESP:    wb_grant = wb_valid;
                default: ;
            endcase
        end
    end

    assign req_ready = rd_grant;
    assign wb_ready  = wb_grant;
    assign rf_we     = wb_grant && !wr_oor && !wr_zero;
    assign wb_err    = wb_grant && wr_oor;
    assign rsp_valid = !rst && (state == RESP);
    assign rsp_err   = rsp_valid && err_q;

    always_comb begin
        rf_addr  = '0;
        rf_wdata = '0;
        if (rf_we) begin
            rf_addr  = wb_addr;
            rf_wdata = wb_data;
        end else if (!rst && state == RD_A) begin
            rf_addr = rs_q;
        end else if (!rst && state == RD_B) begin
            rf_addr = rt_q;
        end
    end

    assign run_inc = (state == IDLE) && wb_grant && req_valid;
    assign run_clr = rd_grant || (wb_grant && !run_inc);

    regfile_seq_runcnt #(.MAX_WB_RUN(MAX_WB_RUN)) u_runcnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (run_inc),
        .clr      (run_clr),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            single_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_grant) begin
                        rs_q     <= rs_addr;
                        rt_q     <= rt_addr;
                        single_q <= req_single;
                        err_q    <= addr_oor(rs_addr, NREGS) ||
                                    (!req_single && addr_oor(rt_addr, NREGS));
                        state    <= RD_A;
                    end
                end
                RD_A: begin
                    op_a <= rd_val(rs_q);
                    if (single_q) begin
                        op_b  <= '0;
                        state <= RESP;
                    end else begin
                        state <= RD_B;
                    end
                end
                RD_B: begin
                    op_b  <= rd_val(rt_q);
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural 16-entry register file attached.
// Covers both builds of REGFILE_SEQ_R0_ZERO_EN.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_single;
    logic [4:0]  rs_addr, rt_addr;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] op_a, op_b;
    logic        wb_valid, wb_ready, wb_err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata, rf_rdata;

    logic [31:0] mem [0:15];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;

    regfile_seq #(.NREGS(16), .MAX_WB_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_single(req_single),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .op_a(op_a), .op_b(op_b), .rsp_err(rsp_err),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_err(wb_err),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Register file model: async read, sync write; out-of-range reads return a poison value.
    assign rf_rdata = (rf_addr < 5'd16) ? mem[rf_addr[3:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hA5A5_A5A5;
            mem[5] <= 32'h0000_0005;
            mem[7] <= 32'h0000_0077;
        end else if (rf_we) begin
            mem[rf_addr[3:0]] <= rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d,
                         input logic exp_we, input logic exp_err);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        #1;
        chk("wb_ready", 32'(wb_ready), 32'd1);
        chk("wb_rf_we", 32'(rf_we), 32'(exp_we));
        chk("wb_err",   32'(wb_err), 32'(exp_err));
        if (exp_we) begin
            chk("wb_rf_addr",  32'(rf_addr), 32'(a));
            chk("wb_rf_wdata", rf_wdata, d);
        end
        step();
        wb_valid = 1'b0;
        #1;
        chk("wb_err_clear", 32'(wb_err), 32'd0);
    endtask

    task automatic do_rd(input logic [4:0] a, input logic [4:0] b, input logic sgl,
                         input logic [31:0] ea, input logic [31:0] eb, input logic eerr);
        int n;
        req_valid = 1'b1; rs_addr = a; rt_addr = b; req_single = sgl; rsp_ready = 1'b0;
        #1;
        chk("rd_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        n = 1;
        chk("rd_addr_rs", 32'(rf_addr), 32'(a));
        chk("rd_no_we", 32'(rf_we), 32'd0);
        if (!sgl) begin
            step();
            n = 2;
            chk("rd_addr_rt", 32'(rf_addr), 32'(b));
        end
        while (!rsp_valid && n < 8) begin
            step();
            n++;
        end
        chk("rd_latency", 32'(n), sgl ? 32'd2 : 32'd3);
        chk("rd_op_a", op_a, ea);
        chk("rd_op_b", op_b, eb);
        chk("rd_rsp_err", 32'(rsp_err), 32'(eerr));
        rsp_ready = 1'b1;
        #1;
        step();
        rsp_ready = 1'b0;
        chk("rd_rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g, cyc;
        rst = 1'b1;
        req_valid = 1'b1; req_single = 1'b0; rs_addr = 5'd1; rt_addr = 5'd2;
        rsp_ready = 1'b0; wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wb_ready",  32'(wb_ready),  32'd0);
        chk("rst_rf_we",     32'(rf_we),     32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_wb_err",    32'(wb_err),    32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        rst = 1'b0; req_valid = 1'b0; wb_valid = 1'b0;
        step();

        // Writeback then two-operand read of the freshly written register.
        do_wb(5'd3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        do_rd(5'd3, 5'd5, 1'b0, 32'hDEAD_BEEF, 32'h5, 1'b0);

        do_rd(5'd7, 5'd0, 1'b1, 32'h77, 32'h0, 1'b0);

        // Starvation bound: four writes win, then the read; writes continue during backpressure.
        req_valid = 1'b1; rs_addr = 5'd9; rt_addr = 5'd0; req_single = 1'b1; rsp_ready = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h100;
        g = 0; cyc = 0;
        #1;
        while (!req_ready && cyc < 20) begin
            if (wb_ready) g++;
            step();
            cyc++;
            wb_data = 32'h100 + 32'(g);
            #1;
        end
        chk("starve_grants", 32'(g), 32'd4);
        chk("starve_req_ready", 32'(req_ready), 32'd1);
        chk("starve_wb_blocked", 32'(wb_ready), 32'd0);
        step();
        req_valid = 1'b0;
        #1;
        chk("rda_no_wb", 32'(wb_ready), 32'd0);
        chk("rda_no_we", 32'(rf_we), 32'd0);
        step();
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wb_grant", 32'(wb_ready), 32'd1);
            chk("bp_rsp_hold", 32'(rsp_valid), 32'd1);
            chk("bp_op_a", op_a, 32'h103);
            chk("bp_op_b", op_b, 32'h0);
            step();
            wb_data = 32'h105 + 32'(i);
            #1;
        end
        rsp_ready = 1'b1; wb_valid = 1'b0;
        #1;
        step();
        rsp_ready = 1'b0;
        chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
        do_rd(5'd9, 5'd7, 1'b0, 32'h108, 32'h77, 1'b0);

        // Out-of-range accesses.
        do_wb(5'd20, 32'hCAFE_F00D, 1'b0, 1'b1);
        do_rd(5'd18, 5'd3, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);

`ifdef REGFILE_SEQ_R0_ZERO_EN
        do_wb(5'd0, 32'h1, 1'b0, 1'b0);
        do_rd(5'd0, 5'd7, 1'b0, 32'h0, 32'h77, 1'b0);
`else
        do_wb(5'd0, 32'h1, 1'b1, 1'b0);
        do_rd(5'd0, 5'd7, 1'b0, 32'h1, 32'h77, 1'b0);
`endif

        // Reset while in RD_B aborts the read with no response.
        req_valid = 1'b1; rs_addr = 5'd3; rt_addr = 5'd5; req_single = 1'b0; rsp_ready = 1'b1;
        #1;
        step();
        req_valid = 1'b0;
        step();
        chk("rdb_addr", 32'(rf_addr), 32'd5);
        rst = 1'b1;
        #1;
        chk("rst_rdb_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdb_rf_addr", 32'(rf_addr), 32'd0);
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            step();
        end
        do_rd(5'd7, 5'd5, 1'b0, 32'h77, 32'h5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
